food_placer: RTL and testbench

Sequencing controller for the random coordinate generator in the snake game. On a placement request it steps the generator, captures the candidate (x,y), asks the snake-body occupancy checker whether that cell is taken, and retries until it finds a free cell or exhausts a retry budget. It sits between the game FSM (request/done), the `lfsr` coordinate generator (enable/outputs) and the body-memory collision logic (query handshake). It also owns the registered food position used by the renderer and the eat-detection logic.

---
 rtl/food_placer.sv | 224 ++++++++++++++++++++++
 tb/tb_food_placer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_placer.sv
// ---------------------------------------------------------------------------
// food_placer
//
// Sequencing controller for the snake game's food placement. On a request it
// pulses the coordinate generator, captures the candidate cell, asks the body
// occupancy checker whether the cell is taken and retries until a free cell is
// found or the retry budget is exhausted. It owns the committed food position.
//
// Optional feature macro: FOOD_BORDER_CHECK_EN
//   When defined, candidates outside X_MIN..X_MAX / Y_MIN..Y_MAX are rejected
//   at the end of SETTLE without issuing a query. When undefined, every
//   candidate is queried.
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   place_req_i    one-cycle placement request (sampled only when idle)
//   food_clear_i   food eaten, drops food_valid_o
//   rng_en_o       generator step enable, one cycle per attempt
//   rng_x_i/rng_y_i generator coordinate outputs
//   query_valid_o  occupancy query pending
//   query_x_o/query_y_o candidate cell under query
//   query_done_i   checker response strobe
//   query_hit_i    cell occupied (qualified by query_done_i)
//   food_x_o/food_y_o committed food cell
//   food_valid_o   a food position is committed
//   busy_o         controller is not idle
//   place_done_o   one-cycle completion pulse
//   place_fail_o   with place_done_o: retry budget exhausted
// ---------------------------------------------------------------------------
module food_placer #(
  parameter int unsigned MAX_TRIES = 16,
  parameter logic [7:0]  X_MIN     = 8'd15,
  parameter logic [7:0]  X_MAX     = 8'd145,
  parameter logic [6:0]  Y_MIN     = 7'd10,
  parameter logic [6:0]  Y_MAX     = 7'd110
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       place_req_i,
  input  logic       food_clear_i,
  output logic       rng_en_o,
  input  logic [7:0] rng_x_i,
  input  logic [6:0] rng_y_i,
  output logic       query_valid_o,
  output logic [7:0] query_x_o,
  output logic [6:0] query_y_o,
  input  logic       query_done_i,
  input  logic       query_hit_i,
  output logic [7:0] food_x_o,
  output logic [6:0] food_y_o,
  output logic       food_valid_o,
  output logic       busy_o,
  output logic       place_done_o,
  output logic       place_fail_o
);

  localparam int unsigned       CNT_W   = $clog2(MAX_TRIES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_TRIES);

  // Reject illegal parameter combinations at elaboration time.
  if ((MAX_TRIES < 1) || (MAX_TRIES > 255) || (X_MIN > X_MAX) || (Y_MIN > Y_MAX)) begin : g_param_check
    $error("food_placer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STEP      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_QUERY     = 3'd3,
    ST_DONE_OK   = 3'd4,
    ST_DONE_FAIL = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] try_q, try_d;
  logic [CNT_W-1:0] try_inc_s;
  logic             budget_out_s;
  logic [7:0]       cand_x_q;
  logic [6:0]       cand_y_q;
  logic [7:0]       food_x_q;
  logic [6:0]       food_y_q;
  logic             food_valid_q;

  logic             rng_en_s;
  logic             query_valid_s;
  logic             busy_s;
  logic             place_done_s;
  logic             place_fail_s;

  // Counter never wraps: it holds at CNT_MAX even if incremented again.
  assign try_inc_s    = (try_q == CNT_MAX) ? try_q : (try_q + CNT_W'(1));
  assign budget_out_s = (try_inc_s == CNT_MAX);

`ifdef FOOD_BORDER_CHECK_EN
  logic cand_in_range_s;

  // Bounds are checked on the generator outputs being captured this cycle.
  assign cand_in_range_s = (rng_x_i >= X_MIN) && (rng_x_i <= X_MAX) &&
                           (rng_y_i >= Y_MIN) && (rng_y_i <= Y_MAX);
`endif

  // State register and try counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      try_q   <= '0;
    end else begin
      state_q <= state_d;
      try_q   <= try_d;
    end
  end

  // Next-state and try-counter logic.
  always_comb begin
    state_d = state_q;
    try_d   = try_q;
    case (state_q)
      ST_IDLE: begin
        if (place_req_i) begin
          try_d   = '0;
          state_d = ST_STEP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
`ifdef FOOD_BORDER_CHECK_EN
        if (cand_in_range_s) begin
          state_d = ST_QUERY;
        end else begin
          try_d   = try_inc_s;
          state_d = budget_out_s ? ST_DONE_FAIL : ST_STEP;
        end
`else
        state_d = ST_QUERY;
`endif
      end
      ST_QUERY: begin
        if (query_done_i) begin
          if (query_hit_i) begin
            try_d   = try_inc_s;
            state_d = budget_out_s ? ST_DONE_FAIL : ST_STEP;
          end else begin
            state_d = ST_DONE_OK;
          end
        end else begin
          state_d = ST_QUERY;
        end
      end
      ST_DONE_OK: begin
        state_d = ST_IDLE;
      end
      ST_DONE_FAIL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output strobes decoded straight from the state register.
  always_comb begin
    rng_en_s      = 1'b0;
    query_valid_s = 1'b0;
    busy_s        = 1'b1;
    place_done_s  = 1'b0;
    place_fail_s  = 1'b0;
    case (state_q)
      ST_IDLE:      busy_s        = 1'b0;
      ST_STEP:      rng_en_s      = 1'b1;
      ST_SETTLE:    busy_s        = 1'b1;
      ST_QUERY:     query_valid_s = 1'b1;
      ST_DONE_OK:   place_done_s  = 1'b1;
      ST_DONE_FAIL: begin
        place_done_s = 1'b1;
        place_fail_s = 1'b1;
      end
      default:      busy_s        = 1'b0;
    endcase
  end

  // Candidate capture at the end of SETTLE; held stable through QUERY.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cand_x_q <= 8'd0;
      cand_y_q <= 7'd0;
    end else if (state_q == ST_SETTLE) begin
      cand_x_q <= rng_x_i;
      cand_y_q <= rng_y_i;
    end
  end

  // Committed food position; a commit takes priority over a same-cycle clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      food_x_q     <= 8'd0;
      food_y_q     <= 7'd0;
      food_valid_q <= 1'b0;
    end else if (state_q == ST_DONE_OK) begin
      food_x_q     <= cand_x_q;
      food_y_q     <= cand_y_q;
      food_valid_q <= 1'b1;
    end else if (food_clear_i) begin
      food_valid_q <= 1'b0;
    end
  end

  assign rng_en_o      = rng_en_s;
  assign query_valid_o = query_valid_s;
  assign query_x_o     = cand_x_q;
  assign query_y_o     = cand_y_q;
  assign food_x_o      = food_x_q;
  assign food_y_o      = food_y_q;
  assign food_valid_o  = food_valid_q;
  assign busy_o        = busy_s;
  assign place_done_o  = place_done_s;
  assign place_fail_o  = place_fail_s;

endmodule

// File: tb/tb_food_placer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for food_placer (MAX_TRIES = 4).
// A placement-level model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_food_placer;

  localparam int MT = 4;
  localparam int P_IDLE = 0, P_ATT = 1, P_OK = 2, P_FAIL = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       place_req, food_clear, query_done, query_hit;
  logic [7:0] rng_x;
  logic [6:0] rng_y;
  logic       rng_en, query_valid, food_valid, busy, place_done, place_fail;
  logic [7:0] query_x, food_x;
  logic [6:0] query_y, food_y;

  always #5 clk = ~clk;

  food_placer #(.MAX_TRIES(MT)) dut (
    .clk_i(clk), .reset_i(reset), .place_req_i(place_req), .food_clear_i(food_clear),
    .rng_en_o(rng_en), .rng_x_i(rng_x), .rng_y_i(rng_y),
    .query_valid_o(query_valid), .query_x_o(query_x), .query_y_o(query_y),
    .query_done_i(query_done), .query_hit_i(query_hit),
    .food_x_o(food_x), .food_y_o(food_y), .food_valid_o(food_valid),
    .busy_o(busy), .place_done_o(place_done), .place_fail_o(place_fail)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (placement timeline) ----------------
  int         m_ph, m_age, m_tries;
  logic [7:0] m_cx, m_fx;
  logic [6:0] m_cy, m_fy;
  logic       m_fv;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph <= P_IDLE; m_age <= 0; m_tries <= 0;
      m_cx <= 8'd0; m_cy <= 7'd0; m_fx <= 8'd0; m_fy <= 7'd0; m_fv <= 1'b0;
    end else begin
      if (m_ph == P_OK) begin
        m_fx <= m_cx; m_fy <= m_cy; m_fv <= 1'b1;
      end else if (food_clear) begin
        m_fv <= 1'b0;
      end
      case (m_ph)
        P_IDLE: if (place_req) begin m_ph <= P_ATT; m_age <= 1; m_tries <= 0; end
        P_OK, P_FAIL: m_ph <= P_IDLE;
        P_ATT: begin
          if (m_age == 1) begin
            m_age <= 2;
          end else if (m_age == 2) begin
            m_cx <= rng_x; m_cy <= rng_y;
`ifdef FOOD_BORDER_CHECK_EN
            if (rng_x < 8'd15 || rng_x > 8'd145 || rng_y < 7'd10 || rng_y > 7'd110) begin
              m_tries <= m_tries + 1;
              if (m_tries + 1 >= MT) m_ph <= P_FAIL; else m_age <= 1;
            end else begin
              m_age <= 3;
            end
`else
            m_age <= 3;
`endif
          end else if (query_done) begin
            if (!query_hit) begin
              m_ph <= P_OK;
            end else begin
              m_tries <= m_tries + 1;
              if (m_tries + 1 >= MT) m_ph <= P_FAIL; else m_age <= 1;
            end
          end
        end
        default: m_ph <= P_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
      chk("rng_en", 32'(rng_en), 32'(m_ph == P_ATT && m_age == 1));
      chk("query_valid", 32'(query_valid), 32'(m_ph == P_ATT && m_age >= 3));
      if (m_ph == P_ATT && m_age >= 3) begin
        chk("query_x", 32'(query_x), 32'(m_cx));
        chk("query_y", 32'(query_y), 32'(m_cy));
      end
      chk("place_done", 32'(place_done), 32'(m_ph == P_OK || m_ph == P_FAIL));
      if (place_done) chk("place_fail", 32'(place_fail), 32'(m_ph == P_FAIL));
      chk("food_valid", 32'(food_valid), 32'(m_fv));
      chk("food_x", 32'(food_x), 32'(m_fx));
      chk("food_y", 32'(food_y), 32'(m_fy));
    end
  end

  // ---------------- stimulus environment ----------------
  bit         noise, wide, rng_fix, last_fail;
  int         policy, hits_left, done_pct, n_rng, n_done, q_resp;
  logic [7:0] fx, last_qx;
  logic [6:0] fy, last_qy;

  // One clock: observe outputs just after the edge, then drive the next inputs.
  task automatic step();
    @(posedge clk); #1;
    if (rng_en) n_rng++;
    if (place_done) begin n_done++; last_fail = place_fail; end
    place_req  = noise && ($urandom_range(0, 9) == 0);
    food_clear = noise && ($urandom_range(0, 24) == 0);
    if (rng_fix) begin
      rng_x = fx; rng_y = fy;
    end else if (wide) begin
      rng_x = 8'($urandom); rng_y = 7'($urandom);
    end else begin
      rng_x = 8'($urandom_range(15, 145)); rng_y = 7'($urandom_range(10, 110));
    end
    query_hit  = 1'($urandom);
    query_done = 1'b0;
    if (query_valid) begin
      if (int'($urandom_range(0, 99)) < done_pct) begin
        query_done = 1'b1; q_resp++; last_qx = query_x; last_qy = query_y;
        case (policy)
          1: query_hit = 1'b1;
          2: begin query_hit = (hits_left > 0); if (hits_left > 0) hits_left--; end
          default: ;
        endcase
      end
    end else if (noise) begin
      query_done = ($urandom_range(0, 7) == 0);
    end
  endtask

  // Issue one request and wait (bounded) for its completion pulse.
  task automatic run_req(input int budget);
    bit seen;
    seen = 1'b0;
    step(); place_req = 1'b1;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (place_done) seen = 1'b1;
    end
    chk("done_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic clr_counts();
    n_rng = 0; n_done = 0; q_resp = 0;
  endtask

  logic [7:0] saved_x;
  logic [6:0] saved_y;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    place_req = 0; food_clear = 0; query_done = 0; query_hit = 0;
    rng_x = 8'd0; rng_y = 7'd0;
    noise = 0; wide = 0; rng_fix = 0; policy = 0; hits_left = 0; done_pct = 100;
    fx = 8'd0; fy = 7'd0; last_fail = 0; last_qx = 8'd0; last_qy = 7'd0;
    clr_counts();
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_food_valid", 32'(food_valid), 32'd0);
    chk("rst_food_x", 32'(food_x), 32'd0);
    chk("rst_query_valid", 32'(query_valid), 32'd0);
    chk("rst_place_done", 32'(place_done), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // 1: immediate free response, (25,40)
    rng_fix = 1; fx = 8'd25; fy = 7'd40; policy = 2; hits_left = 0; done_pct = 100;
    step(); place_req = 1'b1;
    step(); chk("s1_c1_rng_en", 32'(rng_en), 32'd1);
    step(); chk("s1_c2_rng_en", 32'(rng_en), 32'd0);
            chk("s1_c2_query_valid", 32'(query_valid), 32'd0);
    step(); chk("s1_c3_query_valid", 32'(query_valid), 32'd1);
            chk("s1_c3_query_x", 32'(query_x), 32'd25);
            chk("s1_c3_query_y", 32'(query_y), 32'd40);
    step(); chk("s1_c4_place_done", 32'(place_done), 32'd1);
            chk("s1_c4_place_fail", 32'(place_fail), 32'd0);
            chk("s1_c4_food_valid", 32'(food_valid), 32'd0);
    step(); chk("s1_food_x", 32'(food_x), 32'd25);
            chk("s1_food_y", 32'(food_y), 32'd40);
            chk("s1_food_valid", 32'(food_valid), 32'd1);
            chk("s1_busy", 32'(busy), 32'd0);
            chk("s1_model_food_x", 32'(m_fx), 32'd25);

    // 2: three hits then free, random response delay
    rng_fix = 0; policy = 2; hits_left = 3; done_pct = 50; clr_counts();
    run_req(200);
    chk("s2_rng_pulses", 32'(n_rng), 32'd4);
    chk("s2_queries", 32'(q_resp), 32'd4);
    chk("s2_place_fail", 32'(last_fail), 32'd0);
    step();
    chk("s2_food_x", 32'(food_x), 32'(last_qx));
    chk("s2_food_y", 32'(food_y), 32'(last_qy));
    saved_x = food_x; saved_y = food_y;

    // 3: always hit -> budget exhausted, food unchanged
    policy = 1; done_pct = 60; clr_counts();
    run_req(300);
    chk("s3_queries", 32'(q_resp), 32'd4);
    chk("s3_rng_pulses", 32'(n_rng), 32'd4);
    chk("s3_place_fail", 32'(last_fail), 32'd1);
    step();
    chk("s3_food_x_kept", 32'(food_x), 32'(saved_x));
    chk("s3_food_y_kept", 32'(food_y), 32'(saved_y));
    chk("s3_food_valid_kept", 32'(food_valid), 32'd1);

    // 4: request while busy ignored; clear in DONE_OK loses to commit
    policy = 2; hits_left = 0; done_pct = 100; clr_counts();
    step(); place_req = 1'b1;
    step(); place_req = 1'b1;
    step(); step();
    step(); chk("s4_c4_place_done", 32'(place_done), 32'd1);
            place_req = 1'b1; food_clear = 1'b1;
    step(); chk("s4_food_valid_after_commit", 32'(food_valid), 32'd1);
            chk("s4_idle_after_done", 32'(busy), 32'd0);
    repeat (6) step();
    chk("s4_single_done", 32'(n_done), 32'd1);
    chk("s4_rng_pulses", 32'(n_rng), 32'd1);
    food_clear = 1'b1;
    step(); chk("s4_clear_in_idle", 32'(food_valid), 32'd0);

    // 5: reset during QUERY with no response
    done_pct = 0; clr_counts();
    step(); place_req = 1'b1;
    repeat (4) step();
    chk("s5_in_query", 32'(query_valid), 32'd1);
    reset = 1'b1; #1;
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_query_valid", 32'(query_valid), 32'd0);
    chk("s5_food_valid", 32'(food_valid), 32'd0);
    chk("s5_place_done", 32'(place_done), 32'd0);
    step(); reset = 1'b0;
    repeat (4) step();
    chk("s5_no_done", 32'(n_done), 32'd0);

`ifdef FOOD_BORDER_CHECK_EN
    // 6: out-of-range candidate rejected without a query
    rng_fix = 1; fx = 8'd150; fy = 7'd40; policy = 2; hits_left = 0; done_pct = 100;
    step(); place_req = 1'b1;
    step();
    step(); fx = 8'd30; fy = 7'd20;
    step(); chk("b_c3_rng_en", 32'(rng_en), 32'd1);
            chk("b_c3_no_query", 32'(query_valid), 32'd0);
    step();
    step(); chk("b_c5_query_x", 32'(query_x), 32'd30);
    step();
    step(); chk("b_food_x", 32'(food_x), 32'd30);
            chk("b_food_y", 32'(food_y), 32'd20);
            chk("b_model_tries", 32'(m_tries), 32'd1);
    rng_fix = 0;
`endif

    // 7: randomized soak with noise on every input
    rng_fix = 0; noise = 1; wide = 1; policy = 0; done_pct = 35;
    repeat (2500) step();
    policy = 1; done_pct = 50;
    repeat (1000) step();
    noise = 0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
